hash_text_buffer: RTL and testbench

- Double-buffered character-cell screen memory for the VGA text display of the miner status.
- Accepts a hash-input/hash-output snapshot through a valid/ready handshake.
- A writer FSM expands each snapshot into one glyph index per hex nibble in the back page. The page is swapped onto the display only at a frame boundary.
- The VGA character renderer reads glyph indices from the front page by (x, y) cell coordinates, with 1-cycle latency.

---
 rtl/hash_disp_pkg.sv | 27 ++
 rtl/text_page_ram.sv | 32 +++
 rtl/hash_text_buffer.sv | 179 +++++++++++++++++
 tb/tb_hash_text_buffer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_disp_pkg.sv
// Shared constants and writer state encoding for the hash text display.
// Default geometry places the input block at row 0 and the output block at row 5.
package hash_disp_pkg;

    localparam int COLS_DEF     = 128;
    localparam int ROWS_DEF     = 32;
    localparam int CHAR_W_DEF   = 8;
    localparam int IN_W_DEF     = 1024;
    localparam int OUT_W_DEF    = 256;
    localparam int NPR_DEF      = 64;
    localparam int IN_ROW0_DEF  = 0;
    localparam int OUT_ROW0_DEF = 5;

    localparam logic [7:0] BLANK_GLYPH = 8'h16;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        WR_IN,
        WR_OUT
    } wr_state_e;

    function automatic int nib_rows(input int width, input int npr);
        return width / (4 * npr);
    endfunction

endpackage

// File: rtl/text_page_ram.sv
// Simple dual-port glyph memory: one write port, one registered read port.
// Written as a plain array so synthesis maps it onto block RAM.
module text_page_ram #(
    parameter int AW = 13,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/hash_text_buffer.sv
// Double-buffered character screen for the miner hash status.
// A writer FSM fills the back page; pages swap only at vertical blank.
module hash_text_buffer
    import hash_disp_pkg::*;
#(
    parameter int                COLS     = COLS_DEF,
    parameter int                ROWS     = ROWS_DEF,
    parameter int                CHAR_W   = CHAR_W_DEF,
    parameter int                IN_W     = IN_W_DEF,
    parameter int                OUT_W    = OUT_W_DEF,
    parameter int                NPR      = NPR_DEF,
    parameter int                IN_ROW0  = IN_ROW0_DEF,
    parameter int                OUT_ROW0 = OUT_ROW0_DEF,
    parameter logic [CHAR_W-1:0] BLANK    = CHAR_W'(BLANK_GLYPH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [IN_W-1:0]          hashin,
    input  logic [OUT_W-1:0]         hashout,
    input  logic                     frame_sync,
    input  logic [$clog2(COLS)-1:0]  rd_x,
    input  logic [$clog2(ROWS)-1:0]  rd_y,
    output logic [CHAR_W-1:0]        rd_index,
    output logic                     busy,
    output logic                     front_page
);

    localparam int XW      = $clog2(COLS);
    localparam int YW      = $clog2(ROWS);
    localparam int AW      = 1 + YW + XW;
    localparam int NIB_MAX = (IN_W > OUT_W ? IN_W : OUT_W) / 4;
    localparam int KW      = $clog2(NIB_MAX);
    localparam int CW      = AW > KW ? AW : KW;
    localparam int IN_ROWS  = nib_rows(IN_W, NPR);
    localparam int OUT_ROWS = nib_rows(OUT_W, NPR);

    localparam logic [CW-1:0] CLR_LAST = CW'(2 * COLS * ROWS - 1);
    localparam logic [CW-1:0] IN_LAST  = CW'(IN_W / 4 - 1);
    localparam logic [CW-1:0] OUT_LAST = CW'(OUT_W / 4 - 1);

    if (!((IN_ROW0 + IN_ROWS <= OUT_ROW0) ||
          (OUT_ROW0 + OUT_ROWS <= IN_ROW0))) begin : g_overlap
        $error("hash input and output rows overlap");
    end
    if ((IN_ROW0 + IN_ROWS > ROWS) ||
        (OUT_ROW0 + OUT_ROWS > ROWS) || (NPR > COLS)) begin : g_fit
        $error("hash blocks do not fit on the screen");
    end

    wr_state_e         state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [IN_W-1:0]   in_sh;
    logic [OUT_W-1:0]  out_sh;
    logic              swap_pending;
    logic              capture, shift_in, shift_out, set_swap;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [CHAR_W-1:0] wdata;
    logic [31:0]       kk;
    logic [XW-1:0]     nib_col;
    logic [YW-1:0]     in_row, out_row;

    // nibble k lands at column k mod NPR of its block's k/NPR-th row
    assign kk      = 32'(cnt);
    assign nib_col = XW'(kk % NPR);
    assign in_row  = YW'(kk / NPR + IN_ROW0);
    assign out_row = YW'(kk / NPR + OUT_ROW0);

    assign busy       = (state != IDLE);
    assign load_ready = (state == IDLE) && !swap_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= CLEAR;
            cnt          <= '0;
            front_page   <= 1'b0;
            swap_pending <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (set_swap) begin
                swap_pending <= 1'b1;
            end else if (frame_sync && swap_pending) begin
                swap_pending <= 1'b0;
                front_page   <= ~front_page;
            end
        end
    end

    // shadows shift MSB-first so the top nibble is always the next to draw
    always_ff @(posedge clk) begin
        if (capture) begin
            in_sh  <= hashin;
            out_sh <= hashout;
        end else begin
            if (shift_in) begin
                in_sh <= in_sh << 4;
            end
            if (shift_out) begin
                out_sh <= out_sh << 4;
            end
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        capture   = 1'b0;
        shift_in  = 1'b0;
        shift_out = 1'b0;
        set_swap  = 1'b0;
        we        = 1'b0;
        waddr     = cnt[AW-1:0];
        wdata     = BLANK;
        unique case (state)
            CLEAR: begin
                we = 1'b1;
                if (cnt == CLR_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            IDLE: begin
                if (load_valid && load_ready) begin
                    capture = 1'b1;
                    cnt_n   = '0;
                    state_n = WR_IN;
                end
            end
            WR_IN: begin
                we       = 1'b1;
                waddr    = {~front_page, in_row, nib_col};
                wdata    = CHAR_W'(in_sh[IN_W-1 -: 4]);
                shift_in = 1'b1;
                if (cnt == IN_LAST) begin
                    cnt_n   = '0;
                    state_n = WR_OUT;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            WR_OUT: begin
                we        = 1'b1;
                waddr     = {~front_page, out_row, nib_col};
                wdata     = CHAR_W'(out_sh[OUT_W-1 -: 4]);
                shift_out = 1'b1;
                if (cnt == OUT_LAST) begin
                    cnt_n    = '0;
                    set_swap = 1'b1;
                    state_n  = IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = CLEAR;
            end
        endcase
    end

    text_page_ram #(
        .AW (AW),
        .DW (CHAR_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr ({front_page, rd_y, rd_x}),
        .rdata (rd_index)
    );

endmodule

// File: tb/tb_hash_text_buffer.sv
// Directed bench for hash_text_buffer: clear timing, snapshot layout,
// handshake back-pressure, swap timing, reset abort and read latency.
module tb_hash_text_buffer;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_valid;
    logic          load_ready;
    logic [1023:0] hashin;
    logic [255:0]  hashout;
    logic          frame_sync;
    logic [6:0]    rd_x;
    logic [4:0]    rd_y;
    logic [7:0]    rd_index;
    logic          busy;
    logic          front_page;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int         x;
        int         y;
        logic [7:0] exp;
    } vec_t;

    vec_t pvec[10];

    logic [1023:0] pin, xin;
    logic [255:0]  pout, xout;

    logic [1023:0] mhi[2];
    logic [255:0]  mho[2];
    bit            mv[2];
    int            fp;

    always #5 clk = ~clk;

    hash_text_buffer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .hashin     (hashin),
        .hashout    (hashout),
        .frame_sync (frame_sync),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_index   (rd_index),
        .busy       (busy),
        .front_page (front_page)
    );

    function automatic logic [7:0] model(input int pg, input int x, input int y);
        logic [1023:0] t;
        logic [255:0]  u;
        int            k;
        if (!mv[pg]) return 8'h16;
        if (x < 64 && y >= 0 && y < 4) begin
            k = y * 64 + x;
            t = mhi[pg] >> (4 * (255 - k));
            return {4'h0, t[3:0]};
        end
        if (x < 64 && y == 5) begin
            u = mho[pg] >> (4 * (63 - x));
            return {4'h0, u[3:0]};
        end
        return 8'h16;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic read_chk(input string nm, input int x, input int y, input logic [7:0] exp);
        rd_x = 7'(x);
        rd_y = 5'(y);
        @(negedge clk);
        chk(nm, 32'(rd_index), 32'(exp));
    endtask

    task automatic pulse_sync();
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic start_load(input logic [1023:0] hi, input logic [255:0] ho);
        int n;
        load_valid = 1'b1;
        hashin     = hi;
        hashout    = ho;
        n = 0;
        while (!load_ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("load_ready_seen", 32'(load_ready), 32'd1);
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    initial begin
        int n;
        int bad;
        int px, py;

        pvec[0] = '{0, 0, 8'h00};
        pvec[1] = '{1, 0, 8'h01};
        pvec[2] = '{15, 3, 8'h0F};
        pvec[3] = '{0, 5, 8'h0F};
        pvec[4] = '{63, 5, 8'h00};
        pvec[5] = '{64, 0, 8'h16};
        pvec[6] = '{0, 4, 8'h16};
        pvec[7] = '{16, 1, 8'h00};
        pvec[8] = '{63, 3, 8'h0F};
        pvec[9] = '{62, 5, 8'h01};

        pin  = {16{64'h0123456789ABCDEF}};
        pout = {4{64'hFEDCBA9876543210}};
        xin  = {256{4'hA}};
        xout = {64{4'h5}};
        mv[0] = 1'b0;
        mv[1] = 1'b0;
        fp    = 0;

        rst_n      = 1'b1;
        load_valid = 1'b0;
        hashin     = '0;
        hashout    = '0;
        frame_sync = 1'b0;
        rd_x       = '0;
        rd_y       = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_ready", 32'(load_ready), 32'd0);
        chk("rst_front", 32'(front_page), 32'd0);
        chk("rst_rd_index", 32'(rd_index), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        wait_idle(n);
        chk("clear_cycles", 32'(n), 32'd8192);
        chk("ready_after_clear", 32'(load_ready), 32'd1);
        read_chk("blank_0_0", 0, 0, 8'h16);
        read_chk("blank_127_31", 127, 31, 8'h16);
        read_chk("blank_10_5", 10, 5, 8'h16);

        // first snapshot into page 1, then swap onto the display
        start_load(pin, pout);
        wait_idle(n);
        chk("write_cycles", 32'(n), 32'd320);
        mhi[1] = pin; mho[1] = pout; mv[1] = 1'b1;
        pulse_sync();
        fp = 1;
        chk("swap1_front", 32'(front_page), 32'd1);
        for (int i = 0; i < 10; i++) begin
            read_chk($sformatf("p1_cell_%0d_%0d", pvec[i].x, pvec[i].y),
                     pvec[i].x, pvec[i].y, pvec[i].exp);
        end

        // producer holds valid: one capture, next only after the swap
        load_valid = 1'b1;
        hashin     = xin;
        hashout    = xout;
        @(negedge clk);
        bad = 0;
        n   = 0;
        while (busy && n < 1000) begin
            if (load_ready) bad++;
            @(negedge clk);
            n++;
        end
        chk("hold_write_cycles", 32'(n), 32'd320);
        repeat (5) begin
            @(negedge clk);
            if (load_ready || busy) bad++;
        end
        chk("hold_no_capture", 32'(bad), 32'd0);
        mhi[0] = xin; mho[0] = xout; mv[0] = 1'b1;
        pulse_sync();
        fp = 0;
        chk("hold_swap_front", 32'(front_page), 32'd0);
        chk("hold_ready_after_swap", 32'(load_ready), 32'd1);
        @(negedge clk);
        load_valid = 1'b0;
        chk("hold_second_capture", 32'(busy), 32'd1);
        wait_idle(n);
        mhi[1] = xin; mho[1] = xout; mv[1] = 1'b1;
        read_chk("x_0_0", 0, 0, 8'h0A);
        read_chk("x_3_5", 3, 5, 8'h05);
        read_chk("x_0_4", 0, 4, 8'h16);

        // frame_sync coincident with the last write is not honoured
        pulse_sync();
        fp = 1;
        chk("swap3_front", 32'(front_page), 32'd1);
        start_load(pin, pout);
        for (int i = 0; i < 319; i++) @(negedge clk);
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
        chk("late_sync_busy", 32'(busy), 32'd0);
        chk("late_sync_no_swap", 32'(front_page), 32'd1);
        repeat (3) @(negedge clk);
        chk("late_sync_still", 32'(front_page), 32'd1);
        mhi[0] = pin; mho[0] = pout; mv[0] = 1'b1;
        pulse_sync();
        fp = 0;
        chk("late_sync_next_swap", 32'(front_page), 32'd0);
        for (int i = 0; i < 10; i++) begin
            read_chk($sformatf("p0_cell_%0d_%0d", pvec[i].x, pvec[i].y),
                     pvec[i].x, pvec[i].y, pvec[i].exp);
        end
        pulse_sync();
        chk("idle_sync_ignored", 32'(front_page), 32'd0);

        // random display reads while the writer fills the back page
        start_load(xin, xout);
        px = $urandom_range(0, 127);
        py = $urandom_range(0, 7);
        rd_x = 7'(px);
        rd_y = 5'(py);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            chk($sformatf("rand_rd_%0d_%0d", px, py), 32'(rd_index), 32'(model(fp, px, py)));
            px = $urandom_range(0, 127);
            py = (i % 2 == 0) ? $urandom_range(0, 7) : $urandom_range(0, 31);
            rd_x = 7'(px);
            rd_y = 5'(py);
        end
        chk("rand_writer_busy", 32'(busy), 32'd1);
        wait_idle(n);
        mhi[1] = xin; mho[1] = xout; mv[1] = 1'b1;
        pulse_sync();
        fp = 1;
        chk("swap_before_abort", 32'(front_page), 32'd1);

        // reset in the middle of WR_IN
        start_load(pin, pout);
        repeat (99) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd1);
        chk("abort_ready", 32'(load_ready), 32'd0);
        chk("abort_front", 32'(front_page), 32'd0);
        chk("abort_rd_index", 32'(rd_index), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle(n);
        chk("abort_clear_cycles", 32'(n), 32'd8192);
        mv[0] = 1'b0;
        mv[1] = 1'b0;
        fp    = 0;
        read_chk("abort_p0_0_0", 0, 0, 8'h16);
        read_chk("abort_p0_63_3", 63, 3, 8'h16);
        read_chk("abort_p0_0_5", 0, 5, 8'h16);
        start_load(pin, pout);
        wait_idle(n);
        mhi[1] = pin; mho[1] = pout; mv[1] = 1'b1;
        pulse_sync();
        fp = 1;
        chk("abort_swap_front", 32'(front_page), 32'd1);
        read_chk("abort_p1_0_0", 0, 0, model(1, 0, 0));
        read_chk("abort_p1_64_0", 64, 0, 8'h16);
        read_chk("abort_p1_0_4", 0, 4, 8'h16);
        read_chk("abort_p1_127_31", 127, 31, 8'h16);
        pulse_sync();
        chk("abort_idle_sync", 32'(front_page), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
